regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the pipelined MIPS core, succeeding the fixed 2-read/1-write, 32×32 file. It adds N read ports and M write ports with prioritised write-through bypass, a per-register pending scoreboard for hazard detection, and a sequential clear engine that zeroes the file without a global reset. It sits between decode (reads, allocations) and writeback (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W; register 0 is hardwired to zero
- NRD, 2, number of read ports
- NWR, 2, number of write ports; a higher port index has higher priority

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rd_addr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  pending bit of each read address, combinational
- we  in  NWR  write enables
- wa  in  NWR*ADDR_W  write addresses
- wd  in  NWR*DATA_W  write data
- alloc_en  in  1  marks alloc_addr as pending (producer issued)
- alloc_addr  in  ADDR_W  register being allocated
- clr_req  in  1  single-cycle pulse that starts a sequential clear
- clr_busy  out  1  high while the clear engine runs

## Operation
- Storage: registers 1..2^ADDR_W-1, each DATA_W bits. Register 0 always reads 0, is never pending, and ignores writes and allocs.
- Read port k, in priority order:
  - addr == 0 → 0
  - clr_busy → 0
  - highest-index port j with we[j] && wa[j] == addr → wd[j] (bypass)
  - otherwise the stored value
- rd_busy[k] = pending[addr], unmasked by bypass. It reads 0 for addr 0 and while clr_busy.
- Write: at posedge, each register takes wd of the highest-index enabled port addressing it. Non-colliding ports all commit in the same cycle.
- Pending bits:
  - set at posedge on alloc_en (addr != 0)
  - cleared at posedge by any enabled write to that address
  - same-cycle alloc and write to the same address: the bit stays set, because the new producer wins
- Clear FSM, two states:
  - IDLE: clr_req moves to CLR. On entry, idx = 1 and all pending bits clear at the same edge.
  - CLR: each cycle, RF[idx] ← 0 and idx increments. After the cycle that clears register 2^ADDR_W-1, return to IDLE.
  - In CLR, we and alloc_en are ignored and dropped. clr_req is ignored.
- clr_busy = (state == CLR).

## Timing
- Reset (async): all registers 0, all pending 0, state IDLE, idx 1, clr_busy 0. Reset in mid-clear aborts to this state immediately.
- Read latency 0 (combinational). A write is visible through bypass in its own cycle and from storage on the next cycle.
- Pending visibility: alloc at edge t → rd_busy high from cycle t+1. A write at edge t → rd_busy low from t+1.
- Clear duration is exactly 2^ADDR_W-1 cycles of clr_busy high. The first write accepted is in the cycle after clr_busy falls.
- clr_req and a write in the same IDLE cycle: the write commits, and the clear then zeroes that register in turn.
- Index width: idx is ADDR_W bits. The terminal test is idx == all-ones, with no wrap into register 0.

## Test plan
- Reset, then read all addresses on every port → all 0, rd_busy all 0. Write 0xDEADBEEF to r0 → r0 still reads 0.
- we = 2'b11, wa0 = wa1 = 7, wd0 = 0x11, wd1 = 0x22 → same-cycle read of r7 gives 0x22 (bypass), next cycle storage reads 0x22.
- Write 0xA5A5A5A5 to r3 on port 0 while reading r3 on both read ports → both return 0xA5A5A5A5 in the same cycle.
- Alloc r9 → rd_busy high next cycle. Write r9 and alloc r9 in the same cycle → stays high. Write r9 alone → low the following cycle.
- Fill r1..r31 with nonzero values, pulse clr_req → clr_busy high for exactly 31 cycles, writes during that window dropped, afterwards all reads 0.
- Assert reset at clear cycle 10 → clr_busy drops at once, all registers 0, and a write on the next cycle commits normally.

Source files
------------

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/alloc/clear bundle for the multi-port register file
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] wa;
  logic [NWR*DATA_W-1:0] wd;
  logic                  alloc_en;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  clr_req;
  logic                  clr_busy;

  modport master (
    output rd_addr, we, wa, wd, alloc_en, alloc_addr, clr_req,
    input  rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, we, wa, wd, alloc_en, alloc_addr, clr_req,
    output rd_data, rd_busy, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - N-read/M-write register file with bypass, pending scoreboard and clear engine
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic           clk,
  input  logic           reset,
  regfile_mp_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  typedef enum logic {IDLE, CLR} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   idx, idx_next;
  logic                clr_start;
  logic                clr_busy;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= IDX_ONE;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    clr_start  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_next = CLR;
          idx_next   = IDX_ONE;
          clr_start  = 1'b1;
        end
      end
      CLR: begin
        idx_next = idx + IDX_ONE;
        // Stop at the last register so idx never wraps onto r0.
        if (idx == IDX_LAST) begin
          state_next = IDLE;
          idx_next   = IDX_ONE;
        end
      end
    endcase
  end

  assign clr_busy     = (state == CLR);
  assign bus.clr_busy = clr_busy;

  // Ascending port loop: later NBAs win, giving the higher-index port priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pending <= '0;
    end else if (state == CLR) begin
      mem[idx] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.wa[j*ADDR_W +: ADDR_W] != '0) begin
          mem[bus.wa[j*ADDR_W +: ADDR_W]]     <= bus.wd[j*DATA_W +: DATA_W];
          pending[bus.wa[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (bus.alloc_en && bus.alloc_addr != '0) pending[bus.alloc_addr] <= 1'b1;
      if (clr_start) pending <= '0;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[addr];
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.wa[j*ADDR_W +: ADDR_W] == addr) data = bus.wd[j*DATA_W +: DATA_W];
      end
      if (addr == '0 || clr_busy) data = '0;
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[k] = pending[addr] & ~clr_busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  int   cnt;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.we = 2'b00; bus.wa = '0; bus.wd = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0; bus.clr_req = 1'b0;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.we = 2'b01; bus.wa = {5'd0, a}; bus.wd = {32'd0, d};
    @(posedge clk); #1;
    bus.we = 2'b00;
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk({name, "_d0"}, bus.rd_data[31:0], 32'h0);
      chk({name, "_d1"}, bus.rd_data[63:32], 32'h0);
      chk({name, "_busy"}, {30'd0, bus.rd_busy}, 32'h0);
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 2'b00};
    vecs[1]  = '{2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[2]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[3]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 2'b00};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 2'b00};
    vecs[5]  = '{2'b01, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7, 32'hA5A5A5A5, 32'h22, 2'b00};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 2'b00};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0, 2'b01};
    vecs[9]  = '{2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 2'b11};
    vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h99, 32'h99, 2'b11};
    vecs[11] = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 5'd0, 5'd9, 5'd9, 32'h77, 32'h77, 2'b11};
    vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h77, 32'h77, 2'b00};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[14] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[15] = '{2'b11, 5'd4, 5'd5, 32'h44, 32'h55, 1'b0, 5'd0, 5'd4, 5'd5, 32'h44, 32'h55, 2'b00};
    vecs[16] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd5, 32'h44, 32'h55, 2'b00};

    reset = 1'b1;
    idle_inputs();
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clr_busy", {31'd0, bus.clr_busy}, 32'h0);
    check_all_zero("rst_read");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      bus.we = vecs[i].we;
      bus.wa = {vecs[i].wa1, vecs[i].wa0};
      bus.wd = {vecs[i].wd1, vecs[i].wd0};
      bus.alloc_en = vecs[i].alloc_en;
      bus.alloc_addr = vecs[i].alloc_addr;
      bus.rd_addr = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      chk($sformatf("vec%0d_d0", i), bus.rd_data[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_d1", i), bus.rd_data[63:32], vecs[i].e1);
      chk($sformatf("vec%0d_busy", i), {30'd0, bus.rd_busy}, {30'd0, vecs[i].eb});
      @(posedge clk); #1;
    end
    idle_inputs();

    // Sequential clear with writes and allocs arriving during the window.
    for (int i = 1; i < 32; i++) wr1(5'(i), 32'h1000_0000 | i);
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd8;
    @(posedge clk); #1;
    bus.alloc_en = 1'b0;
    bus.rd_addr = {5'd31, 5'd8};
    #1;
    chk("pre_clr_d31", bus.rd_data[63:32], 32'h1000_001F);
    chk("pre_clr_busy8", {30'd0, bus.rd_busy}, 32'h1);
    bus.clr_req = 1'b1;
    bus.we = 2'b10; bus.wa = {5'd2, 5'd0}; bus.wd = {32'hBB, 32'h0};
    @(posedge clk); #1;
    bus.clr_req = 1'b0;
    bus.we = 2'b11; bus.wa = {5'd31, 5'd1}; bus.wd = {32'hF2, 32'hF1};
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd6;
    bus.rd_addr = {5'd31, 5'd1};
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!bus.clr_busy) break;
      cnt++;
      if (cnt == 5) chk("clr_mask_d", bus.rd_data[63:32], 32'h0);
    end
    idle_inputs();
    chk("clr_cycles", cnt, 32'd31);
    check_all_zero("post_clr");
    @(posedge clk); #1;
    wr1(5'd12, 32'hC0FFEE12);
    bus.rd_addr = {5'd12, 5'd12};
    #1;
    chk("post_clr_write", bus.rd_data[31:0], 32'hC0FFEE12);

    // Asynchronous reset in the middle of a clear.
    @(posedge clk); #1;
    wr1(5'd20, 32'h2020);
    wr1(5'd30, 32'h3030);
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd10;
    @(posedge clk); #1;
    bus.alloc_en = 1'b0;
    bus.clr_req = 1'b1;
    @(posedge clk); #1;
    bus.clr_req = 1'b0;
    cnt = 0;
    for (int t = 0; t < 100 && cnt < 10; t++) begin
      @(negedge clk);
      if (bus.clr_busy) cnt++;
    end
    chk("rst_mid_reach10", cnt, 32'd10);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_clr_busy", {31'd0, bus.clr_busy}, 32'h0);
    bus.rd_addr = {5'd30, 5'd20};
    #1;
    chk("rst_mid_d20", bus.rd_data[31:0], 32'h0);
    chk("rst_mid_d30", bus.rd_data[63:32], 32'h0);
    bus.rd_addr = {5'd10, 5'd10};
    #1;
    chk("rst_mid_busy10", {30'd0, bus.rd_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wr1(5'd5, 32'h5555);
    bus.rd_addr = {5'd20, 5'd5};
    #1;
    chk("rst_mid_wr5", bus.rd_data[31:0], 32'h5555);
    chk("rst_mid_r20", bus.rd_data[63:32], 32'h0);
    chk("rst_mid_idle", {31'd0, bus.clr_busy}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
